// File: rtl/audio_mac_arbiter.sv
// Round-robin arbiter sharing one signed multiplier between NREQ audio requesters.
// Three-stage multiply / round / saturate pipeline, results tagged with requester id.
module audio_mac_arbiter #(
   parameter int NREQ  = 4,
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int SHIFT = 14
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hold,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   a,
   input  logic [NREQ*CW-1:0]   b,
   output logic [NREQ-1:0]      gnt,
   output logic                 res_valid,
   output logic [2:0]           res_id,
   output logic [DW-1:0]        res_data
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int MW = DW + CW;
   localparam int SW = MW + 1;

   localparam logic signed [SW-1:0] HALF    = SW'(1) << (SHIFT - 1);
   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   // Handshake: a transfer happens in any cycle where req[i] & gnt[i]; operands and
   // index are captured on that clock edge, and the requester keeps req and operands
   // stable until it sees its grant. There is no back-pressure on the result side.

   logic [PW-1:0]          ptr;
   logic [2:0]             gnt_id;
   logic signed [DW-1:0]   sel_a;
   logic signed [CW-1:0]   sel_b;
   logic                   found;

   logic                   s1_valid;
   logic signed [DW-1:0]   s1_a;
   logic signed [CW-1:0]   s1_b;
   logic [2:0]             s1_id;
   logic                   s2_valid;
   logic signed [MW-1:0]   s2_p;
   logic [2:0]             s2_id;

   logic signed [SW-1:0]   rnd_sum;
   logic signed [SW-1:0]   rnd_shr;
   logic [DW-1:0]          sat_data;

   // Priority search: scan offsets from ptr upward, first asserted request wins.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      sel_a  = '0;
      sel_b  = '0;
      found  = 1'b0;
      if (!reset && !hold) begin
         for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
               if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                  found  = 1'b1;
                  gnt[i] = 1'b1;
                  gnt_id = 3'(i);
                  sel_a  = a[i*DW +: DW];
                  sel_b  = b[i*CW +: CW];
               end
            end
         end
      end
   end

   // Round half toward +inf, then clamp to the signed sample range.
   always_comb begin
      rnd_sum = {s2_p[MW-1], s2_p} + HALF;
      rnd_shr = rnd_sum >>> SHIFT;
      if (rnd_shr > SAT_MAX)
         sat_data = {1'b0, {(DW-1){1'b1}}};
      else if (rnd_shr < SAT_MIN)
         sat_data = {1'b1, {(DW-1){1'b0}}};
      else
         sat_data = rnd_shr[DW-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= '0;
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_data  <= '0;
      end else begin
         if (found)
            ptr <= PW'((int'(gnt_id) + 1) % NREQ);
         s1_valid  <= found;
         s2_valid  <= s1_valid;
         res_valid <= s2_valid;
         if (s2_valid) begin
            res_id   <= s2_id;
            res_data <= sat_data;
         end
      end
   end

   // Datapath registers carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (found) begin
         s1_a  <= sel_a;
         s1_b  <= sel_b;
         s1_id <= gnt_id;
      end
      s2_p  <= s1_a * s1_b;
      s2_id <= s1_id;
   end

endmodule

// File: tb/tb_audio_mac_arbiter.sv
// Directed bench for audio_mac_arbiter: grant rotation, hold, reset flush and
// multiply/round/saturate results checked against hand-computed values.
module tb_audio_mac_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic          hold;
   logic [3:0]    req;
   logic [63:0]   a;
   logic [63:0]   b;
   logic [3:0]    gnt;
   logic          res_valid;
   logic [2:0]    res_id;
   logic [15:0]   res_data;

   int            checks   = 0;
   int            failures = 0;
   logic [18:0]   exp_q[$];
   int            due_q[$];

   audio_mac_arbiter #(.NREQ(4), .DW(16), .CW(16), .SHIFT(14)) dut (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .req       (req),
      .a         (a),
      .b         (b),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_data  (res_data)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1;
      hold  = 1'b0;
      req   = 4'b1111;
      a     = '0;
      b     = '0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000) begin
         failures++;
         $display("FAIL reset_gnt: got %b expected 0000", gnt);
      end
      checks++;
      if (res_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_res_valid: got %b expected 0", res_valid);
      end
      checks++;
      if (res_id !== 3'd0) begin
         failures++;
         $display("FAIL reset_res_id: got %0d expected 0", res_id);
      end
      checks++;
      if (res_data !== 16'd0) begin
         failures++;
         $display("FAIL reset_res_data: got %0d expected 0", res_data);
      end
   endtask

   // Single requester issuing every cycle: arithmetic, rounding and saturation.
   task automatic test_arith();
      logic signed [15:0] va [8] = '{16'sd16384, 16'sd32767, -16'sd32768, -16'sd32768,
                                     -16'sd1, -16'sd3, 16'sd3, -16'sd3};
      logic signed [15:0] vb [8] = '{16'sd16384, 16'sd32767, 16'sd32767, -16'sd32768,
                                     16'sd1, 16'sd16384, 16'sd8192, 16'sd8192};
      logic signed [15:0] vr [8] = '{16'sd16384, 16'sd32767, -16'sd32768, 16'sd32767,
                                     16'sd0, -16'sd3, 16'sd2, -16'sd1};
      logic [18:0] exp_r;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         reset = 1'b0;
         hold  = 1'b0;
         if (c < 8) begin
            req        = 4'b0001;
            a[15:0]    = va[c];
            b[15:0]    = vb[c];
            exp_q.push_back({3'd0, vr[c]});
            due_q.push_back(c + 3);
         end else begin
            req = 4'b0000;
         end
         @(negedge clk);
         if (c < 8) begin
            checks++;
            if (gnt !== 4'b0001) begin
               failures++;
               $display("FAIL arith_gnt c=%0d: got %b expected 0001", c, gnt);
            end
         end
         checks++;
         if (due_q.size() > 0 && due_q[0] == c) begin
            exp_r = exp_q.pop_front();
            void'(due_q.pop_front());
            if (res_valid !== 1'b1 || {res_id, res_data} !== exp_r) begin
               failures++;
               $display("FAIL arith_result c=%0d: got v=%b id=%0d data=%0d expected v=1 id=%0d data=%0d",
                        c, res_valid, res_id, $signed(res_data), exp_r[18:16], $signed(exp_r[15:0]));
            end
         end else if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL arith_idle c=%0d: got res_valid=%b expected 0", c, res_valid);
         end
      end
      checks++;
      if (res_data !== 16'hFFFF || res_id !== 3'd0) begin
         failures++;
         $display("FAIL arith_hold_last: got id=%0d data=%0d expected id=0 data=-1",
                  res_id, $signed(res_data));
      end
   endtask

   // All four requesting for 8 cycles: strict rotation, results in grant order.
   task automatic test_rotation();
      int          a_val [4];
      logic [18:0] exp_r;
      int          gi;
      @(posedge clk);
      #1;
      reset = 1'b1;
      req   = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         a_val[i]         = 1000 * (i + 1);
         a[i*16 +: 16]    = 16'(a_val[i]);
         b[i*16 +: 16]    = 16'd16384;
      end
      for (int c = 0; c < 11; c++) begin
         @(posedge clk);
         #1;
         reset = 1'b0;
         if (c > 0 && c <= 8) begin
            gi                = (c - 1) % 4;
            a_val[gi]         = 1000 * (gi + 1) + 100 * ((c - 1) / 4 + 1);
            a[gi*16 +: 16]    = 16'(a_val[gi]);
         end
         if (c < 8) begin
            req = 4'b1111;
            gi  = c % 4;
            exp_q.push_back({3'(gi), 16'(a_val[gi])});
            due_q.push_back(c + 3);
         end else begin
            req = 4'b0000;
         end
         @(negedge clk);
         if (c < 8) begin
            checks++;
            if (gnt !== 4'(1 << (c % 4))) begin
               failures++;
               $display("FAIL rotation_gnt c=%0d: got %b expected %b", c, gnt, 4'(1 << (c % 4)));
            end
         end
         checks++;
         if (due_q.size() > 0 && due_q[0] == c) begin
            exp_r = exp_q.pop_front();
            void'(due_q.pop_front());
            if (res_valid !== 1'b1 || {res_id, res_data} !== exp_r) begin
               failures++;
               $display("FAIL rotation_result c=%0d: got v=%b id=%0d data=%0d expected v=1 id=%0d data=%0d",
                        c, res_valid, res_id, $signed(res_data), exp_r[18:16], $signed(exp_r[15:0]));
            end
         end else if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL rotation_idle c=%0d: got res_valid=%b expected 0", c, res_valid);
         end
      end
   endtask

   // Two hold cycles mid-stream: no grants, pointer frozen, in-flight ops still emerge.
   task automatic test_hold();
      logic        hold_pat [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0]  exp_g;
      logic [18:0] exp_r;
      int          ng = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      req   = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         a[i*16 +: 16] = 16'(500 * (i + 1));
         b[i*16 +: 16] = 16'd16384;
      end
      for (int c = 0; c < 9; c++) begin
         @(posedge clk);
         #1;
         reset = 1'b0;
         exp_g = 4'b0000;
         if (c < 6) begin
            req  = 4'b1111;
            hold = hold_pat[c];
            if (!hold_pat[c]) begin
               exp_g = 4'(1 << ng);
               exp_q.push_back({3'(ng), 16'(500 * (ng + 1))});
               due_q.push_back(c + 3);
               ng++;
            end
         end else begin
            req  = 4'b0000;
            hold = 1'b0;
         end
         @(negedge clk);
         if (c < 6) begin
            checks++;
            if (gnt !== exp_g) begin
               failures++;
               $display("FAIL hold_gnt c=%0d: got %b expected %b", c, gnt, exp_g);
            end
         end
         checks++;
         if (due_q.size() > 0 && due_q[0] == c) begin
            exp_r = exp_q.pop_front();
            void'(due_q.pop_front());
            if (res_valid !== 1'b1 || {res_id, res_data} !== exp_r) begin
               failures++;
               $display("FAIL hold_result c=%0d: got v=%b id=%0d data=%0d expected v=1 id=%0d data=%0d",
                        c, res_valid, res_id, $signed(res_data), exp_r[18:16], $signed(exp_r[15:0]));
            end
         end else if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_idle c=%0d: got res_valid=%b expected 0", c, res_valid);
         end
      end
   endtask

   // Reset pulse with three ops in flight: they are discarded and ptr returns to 0.
   task automatic test_reset_flight();
      logic [3:0]  exp_g [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000,
                                 4'b0001, 4'b0000, 4'b0000, 4'b0000};
      logic        exp_v [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [15:0] exp_d [8] = '{16'd0, 16'd0, 16'd0, 16'd700, 16'd0, 16'd0, 16'd0, 16'd700};
      @(posedge clk);
      #1;
      reset = 1'b1;
      hold  = 1'b0;
      req   = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         a[i*16 +: 16] = 16'(700 * (i + 1));
         b[i*16 +: 16] = 16'd16384;
      end
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         reset = (c == 3);
         req   = (c < 5) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         checks++;
         if (gnt !== exp_g[c]) begin
            failures++;
            $display("FAIL flush_gnt c=%0d: got %b expected %b", c, gnt, exp_g[c]);
         end
         checks++;
         if (res_valid !== exp_v[c]) begin
            failures++;
            $display("FAIL flush_valid c=%0d: got %b expected %b", c, res_valid, exp_v[c]);
         end
         if (c >= 3) begin
            checks++;
            if (res_data !== exp_d[c] || res_id !== 3'd0) begin
               failures++;
               $display("FAIL flush_data c=%0d: got id=%0d data=%0d expected id=0 data=%0d",
                        c, res_id, res_data, exp_d[c]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_rotation();
      test_hold();
      test_reset_flight();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
